dma_peri_req: RTL
=================

DMA_PERI_REQ -- requirements
Module: dma_peri_req

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: words in the peripheral FIFO; fifo_level_i width is log2(FIFO_DEPTH)+1.
REQ-002 clk_i  input  1  single clock; all logic on the rising edge.
REQ-003 reset_i  input  1  reset, synchronous, active-high.
REQ-004 enable_i  input  1  channel enable from peripheral control register.
REQ-005 start_i  input  1  one-cycle pulse; loads a new transfer.
REQ-006 dir_i  input  1  0 = peripheral is source (RX FIFO drained, p2m); 1 = peripheral is destination (TX FIFO filled, m2p).
REQ-007 xfer_len_i  input  16  total words of the transfer, sampled on start_i.
REQ-008 burst_i  input  4  words per request, sampled on start_i; 0 is treated as 1.
REQ-009 fifo_level_i  input  5  current peripheral FIFO occupancy, 0..16.
REQ-010 REQ_o  output  1  DMA request toward the DMA SYNC stage.
REQ-011 ACK_i  input  1  grant acknowledge from the DMA arbiter (Px_ACK).
REQ-012 beat_i  input  1  one word moved by the DMA engine this cycle.
REQ-013 busy_o  output  1  transfer in progress.
REQ-014 done_o  output  1  one-cycle pulse when the last word completes.
REQ-015 remain_o  output  16  words still to move.
REQ-016 err_o  output  1  sticky protocol error; cleared by an accepted start_i.

Function
REQ-017 States SHALL be IDLE, WAIT_LVL, REQ, XFER, DONE; REQ_o = 1 only in REQ.
REQ-018 IDLE: start_i & enable_i & xfer_len_i != 0 -> WAIT_LVL. The block loads remain = xfer_len_i, latches burst_i, and clears err_o.
REQ-019 IDLE: start_i & enable_i & xfer_len_i == 0 -> DONE; remain_o stays 0.
REQ-020 start_i SHALL be ignored when enable_i = 0 or the state is not IDLE.
REQ-021 Burst size SHALL be cur = min(burst, remain), recomputed on every WAIT_LVL exit.
REQ-022 WAIT_LVL -> REQ when ACK_i = 0 and one of the following holds; cur is latched into burst_cnt.
  - dir_i = 0: fifo_level_i >= cur.
  - dir_i = 1: FIFO_DEPTH - fifo_level_i >= cur.
REQ-023 REQ -> XFER on the first cycle ACK_i = 1; REQ_o falls on the next edge (four-phase: REQ holds until ACK is seen).
REQ-024 A beat SHALL be counted when beat_i = 1 and either state = XFER, or state = REQ with ACK_i = 1.
  - Each counted beat decrements remain and burst_cnt by 1.
REQ-025 XFER: when burst_cnt reaches 0 (including on a beat in the same cycle), go to DONE if remain = 0, else to WAIT_LVL.
REQ-026 A new REQ_o SHALL NOT rise until ACK_i has been sampled low, so there is at least one idle cycle between requests.
REQ-027 Any uncounted beat_i (wrong state, or burst_cnt = 0) SHALL set err_o and SHALL NOT modify any counter.
REQ-028 ACK_i = 1 in IDLE, WAIT_LVL or DONE SHALL set err_o and cause no state change.
REQ-029 enable_i = 0 in WAIT_LVL SHALL return to IDLE immediately, with no done_o.
REQ-030 enable_i = 0 in REQ or XFER SHALL let the current burst complete, then go to IDLE with no done_o; remain_o holds its residual value.
REQ-031 DONE SHALL pulse done_o for exactly one cycle, then return to IDLE; busy_o = 1 in every state except IDLE.

Reset
REQ-032 reset_i SHALL force the following on the next edge, regardless of state (including mid-burst): state IDLE, REQ_o = 0, busy_o = 0, done_o = 0, err_o = 0, remain_o = 0, burst_cnt = 0.

Verification
REQ-033 RX flow: dir 0, len 8, burst 4, level 4.
  - REQ_o rises 1 cycle after entering WAIT_LVL.
  - ACK, then 4 beats; second REQ; 4 beats.
  - Response: done_o pulses once, remain_o = 0, err_o = 0.
REQ-034 Partial last burst: len 6, burst 4, level 16.
  - Response: second request expects exactly 2 beats; done_o follows the 6th beat.
REQ-035 Level gating: dir 1, level 14, burst 4.
  - REQ_o stays low; when level drops to 12, REQ_o rises the next cycle.
REQ-036 Handshake: ACK held high for 3 cycles after the burst ends.
  - Response: no new REQ_o until 1 cycle after ACK falls; err_o = 0.
REQ-037 Errors: beat_i in WAIT_LVL -> err_o = 1 and remain unchanged; a 5th beat in a 4-word burst -> err_o = 1.
REQ-038 Abort and reset.
  - enable_i low mid-XFER: burst finishes, state IDLE, no done_o, remain_o = residual.
  - reset_i in REQ: REQ_o = 0 on the next cycle.

Source files
------------

// File: rtl/dma_peri_req.sv
// Peripheral-side DMA request generator: paces REQ/ACK bursts against the
// peripheral FIFO level and tracks the remaining words of one transfer.
module dma_peri_req #(
  parameter  int FIFO_DEPTH = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic [15:0]      xfer_len_i,
  input  logic [3:0]       burst_i,
  input  logic [LVL_W-1:0] fifo_level_i,
  output logic             REQ_o,
  input  logic             ACK_i,
  input  logic             beat_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      remain_o,
  output logic             err_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_LVL = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_XFER     = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] remain_q, remain_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic [4:0]  burst_q, burst_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic        ack_pend_q, ack_pend_d;

  logic        beat_ok;
  logic        ack_err;
  logic        abort_now;
  logic        lvl_ok;
  logic [15:0] cur;
  logic [16:0] lvl_x;

  function automatic logic [15:0] min_burst(input logic [4:0] b, input logic [15:0] r);
    logic [15:0] bx;
    bx = {11'd0, b};
    return (bx < r) ? bx : r;
  endfunction

  assign cur   = min_burst(burst_q, remain_q);
  assign lvl_x = {{(17-LVL_W){1'b0}}, fifo_level_i};
  assign lvl_ok = dir_i ? ((lvl_x + {1'b0, cur}) <= 17'(FIFO_DEPTH))
                        : (lvl_x >= {1'b0, cur});

  // Words only move while the grant is live; anything else is a protocol error.
  assign beat_ok = beat_i && (burst_cnt_q != 16'd0) &&
                   ((state_q == S_XFER) || ((state_q == S_REQ) && ACK_i));

  // ACK lingering from the previous handshake (four-phase tail) is legal.
  assign ack_err = ACK_i && !ack_pend_q &&
                   ((state_q == S_IDLE) || (state_q == S_WAIT_LVL) || (state_q == S_DONE));

  assign abort_now = abort_q || !enable_i;

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    burst_cnt_d = burst_cnt_q;
    burst_d     = burst_q;
    err_d       = err_q;
    abort_d     = abort_q;
    ack_pend_d  = ACK_i ? (ack_pend_q || (state_q == S_REQ)) : 1'b0;

    if (beat_i && !beat_ok) err_d = 1'b1;
    if (ack_err)            err_d = 1'b1;
    if (beat_ok) begin
      remain_d    = remain_q - 16'd1;
      burst_cnt_d = burst_cnt_q - 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start_i && enable_i && !ack_err) begin
          err_d       = 1'b0;
          burst_d     = (burst_i == 4'd0) ? 5'd1 : {1'b0, burst_i};
          remain_d    = xfer_len_i;
          burst_cnt_d = 16'd0;
          state_d     = (xfer_len_i != 16'd0) ? S_WAIT_LVL : S_DONE;
        end
      end
      S_WAIT_LVL: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (!ACK_i && lvl_ok) begin
          burst_cnt_d = cur;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (!enable_i) abort_d = 1'b1;
        if (ACK_i)     state_d = S_XFER;
      end
      S_XFER: begin
        abort_d = abort_now;
        if (burst_cnt_d == 16'd0) begin
          if (abort_now)              state_d = S_IDLE;
          else if (remain_d == 16'd0) state_d = S_DONE;
          else                        state_d = S_WAIT_LVL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      remain_q    <= 16'd0;
      burst_cnt_q <= 16'd0;
      burst_q     <= 5'd1;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      ack_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      burst_cnt_q <= burst_cnt_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      ack_pend_q  <= ack_pend_d;
    end
  end

  assign REQ_o    = (state_q == S_REQ);
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign remain_o = remain_q;
  assign err_o    = err_q;

endmodule
